// File: rtl/cache_arb_pkg.sv
// Shared definitions for the I-cache / D-cache arbiter in front of the
// cacheline adaptor: FSM state encodings, grant identity and line-offset helpers.
package cache_arb_pkg;

    // Arbiter FSM state encodings
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_I    = 2'd1;
    localparam logic [1:0] ARB_D    = 2'd2;
    localparam logic [1:0] ARB_DONE = 2'd3;

    // Which cache received the most recent grant
    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    // Number of address bits that select a byte within one cacheline
    function automatic int line_off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    // Line-offset width for the standard 256-bit line
    localparam int DEFAULT_LINE_W = 256;
    localparam int LINE_OFF_W     = line_off_w(DEFAULT_LINE_W);

endpackage

// File: rtl/cache_arbiter.sv
// Shares the single cacheline adaptor between the instruction and data caches.
// One line transfer at a time; simultaneous requests are resolved round-robin.
// The granted request is captured so the adaptor only ever sees stable,
// registered address/data, and the adaptor response is steered back to the
// granted cache only. A saturating counter records how often both caches
// collided in the idle state.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_pmem_read,
    input  logic [ADDR_W-1:0]   i_pmem_address,
    output logic [LINE_W-1:0]   i_pmem_rdata,
    output logic                i_pmem_resp,

    input  logic                d_pmem_read,
    input  logic                d_pmem_write,
    input  logic [ADDR_W-1:0]   d_pmem_address,
    input  logic [LINE_W-1:0]   d_pmem_wdata,
    input  logic [LINE_W/8-1:0] d_pmem_mbe,
    output logic [LINE_W-1:0]   d_pmem_rdata,
    output logic                d_pmem_resp,

    output logic                read_i,
    output logic                write_i,
    output logic [ADDR_W-1:0]   ca_address,
    output logic [LINE_W-1:0]   ca_wdata,
    output logic [LINE_W/8-1:0] ca_mbe,
    input  logic [LINE_W-1:0]   ca_rdata,
    input  logic                resp_o,

    output logic [CNT_W-1:0]    conflict_count
);

    localparam int OFF_W = line_off_w(LINE_W);
    localparam int MBE_W = LINE_W / 8;

    logic [1:0]        state;
    grant_e            last_grant;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_address;
    logic [LINE_W-1:0] lat_wdata;
    logic [MBE_W-1:0]  lat_mbe;

    logic              i_req;
    logic              d_req;
    logic              tie;
    logic              pick_d;
    logic              grant_now;
    logic [ADDR_W-1:0] i_line_addr;
    logic [ADDR_W-1:0] d_line_addr;

    // Request decode and round-robin pick: D wins unless I also asks and D had the last grant
    always_comb begin
        i_req       = i_pmem_read;
        d_req       = d_pmem_read | d_pmem_write;
        tie         = i_req & d_req;
        pick_d      = d_req & (~i_req | (last_grant == GRANT_I));
        grant_now   = (state == ARB_IDLE) & (i_req | d_req);
        i_line_addr = {i_pmem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        d_line_addr = {d_pmem_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    // Transfer FSM: grant from idle, wait for the adaptor, then one recovery cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_d)
                        state <= ARB_D;
                    else if (i_req)
                        state <= ARB_I;
                end
                ARB_I, ARB_D: begin
                    if (resp_o)
                        state <= ARB_DONE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Capture the winning request so the adaptor sees stable, line-aligned signals
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= GRANT_I;
            lat_write   <= 1'b0;
            lat_address <= '0;
            lat_wdata   <= '0;
            lat_mbe     <= '0;
        end else if (grant_now) begin
            if (pick_d) begin
                last_grant  <= GRANT_D;
                lat_write   <= d_pmem_write;
                lat_address <= d_line_addr;
                lat_wdata   <= d_pmem_wdata;
                lat_mbe     <= d_pmem_mbe;
            end else begin
                last_grant  <= GRANT_I;
                lat_write   <= 1'b0;
                lat_address <= i_line_addr;
                lat_wdata   <= '0;
                lat_mbe     <= '0;
            end
        end
    end

    // Count idle-state collisions, holding at all-ones once full
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conflict_count <= '0;
        else if ((state == ARB_IDLE) && tie && (conflict_count != {CNT_W{1'b1}}))
            conflict_count <= conflict_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Adaptor strobes exist only while a transfer is being served
    always_comb begin
        read_i  = ((state == ARB_I) || (state == ARB_D)) && !lat_write;
        write_i = (state == ARB_D) && lat_write;
    end

    // Adaptor-side data comes from the capture registers; responses go only to the owner
    always_comb begin
        ca_address   = lat_address;
        ca_wdata     = lat_wdata;
        ca_mbe       = lat_mbe;
        i_pmem_rdata = ca_rdata;
        d_pmem_rdata = ca_rdata;
        i_pmem_resp  = (state == ARB_I) && resp_o;
        d_pmem_resp  = (state == ARB_D) && resp_o;
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: single-sided transfers, write-data
// capture, round-robin ties, back-to-back contention, counter saturation
// and reset in the middle of a transfer.
module tb_cache_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    localparam int MBE_W  = LINE_W / 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_pmem_read = 1'b0;
    logic [ADDR_W-1:0] i_pmem_address = '0;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read = 1'b0;
    logic              d_pmem_write = 1'b0;
    logic [ADDR_W-1:0] d_pmem_address = '0;
    logic [LINE_W-1:0] d_pmem_wdata = '0;
    logic [MBE_W-1:0]  d_pmem_mbe = '0;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              read_i;
    logic              write_i;
    logic [ADDR_W-1:0] ca_address;
    logic [LINE_W-1:0] ca_wdata;
    logic [MBE_W-1:0]  ca_mbe;
    logic [LINE_W-1:0] ca_rdata = '0;
    logic              resp_o = 1'b0;
    logic [CNT_W-1:0]  conflict_count;

    int checks = 0;
    int errors = 0;

    localparam logic [ADDR_W-1:0] IA = 32'h1000_0040;
    localparam logic [ADDR_W-1:0] DA = 32'h2000_0080;
    localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] PAT_5A = {32{8'h5A}};
    localparam logic [LINE_W-1:0] PAT_RD = {8{32'hDEAD_BEEF}};

    cache_arbiter #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_pmem_read   (i_pmem_read),
        .i_pmem_address(i_pmem_address),
        .i_pmem_rdata  (i_pmem_rdata),
        .i_pmem_resp   (i_pmem_resp),
        .d_pmem_read   (d_pmem_read),
        .d_pmem_write  (d_pmem_write),
        .d_pmem_address(d_pmem_address),
        .d_pmem_wdata  (d_pmem_wdata),
        .d_pmem_mbe    (d_pmem_mbe),
        .d_pmem_rdata  (d_pmem_rdata),
        .d_pmem_resp   (d_pmem_resp),
        .read_i        (read_i),
        .write_i       (write_i),
        .ca_address    (ca_address),
        .ca_wdata      (ca_wdata),
        .ca_mbe        (ca_mbe),
        .ca_rdata      (ca_rdata),
        .resp_o        (resp_o),
        .conflict_count(conflict_count)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ir, input logic dr, input logic dw,
                                 input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                                 input logic [LINE_W-1:0] wd, input logic [MBE_W-1:0] mbe);
        i_pmem_read    = ir;
        d_pmem_read    = dr;
        d_pmem_write   = dw;
        i_pmem_address = ia;
        d_pmem_address = da;
        d_pmem_wdata   = wd;
        d_pmem_mbe     = mbe;
    endtask

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                               input logic [LINE_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        checkOutput("rst_read_i", read_i, 0);
        checkOutput("rst_write_i", write_i, 0);
        checkOutput("rst_ca_address", ca_address, 0);
        checkOutput("rst_ca_wdata", ca_wdata, 0);
        checkOutput("rst_ca_mbe", ca_mbe, 0);
        checkOutput("rst_i_resp", i_pmem_resp, 0);
        checkOutput("rst_d_resp", d_pmem_resp, 0);
        checkOutput("rst_count", conflict_count, 0);
        cyc();
        rst = 1'b0;

        // I-cache read of 0x1234, line aligned to 0x1220
        $display("[TB] I read");
        applyStimulus(1, 0, 0, 32'h0000_1234, 32'h0, '0, '0);
        ca_rdata = PAT_RD;
        cyc();
        checkOutput("i_read_i", read_i, 1);
        checkOutput("i_write_i", write_i, 0);
        checkOutput("i_ca_address", ca_address, 32'h0000_1220);
        checkOutput("i_ca_mbe", ca_mbe, 0);
        cyc(); cyc(); cyc();
        checkOutput("i_read_hold", read_i, 1);
        checkOutput("i_resp_wait", i_pmem_resp, 0);
        resp_o = 1'b1;
        i_pmem_read = 1'b0;
        #1;
        checkOutput("i_resp", i_pmem_resp, 1);
        checkOutput("i_other_resp", d_pmem_resp, 0);
        checkOutput("i_rdata", i_pmem_rdata, PAT_RD);
        checkOutput("d_rdata_shared", d_pmem_rdata, PAT_RD);
        cyc();
        resp_o = 1'b0;
        #1;
        checkOutput("i_done_read", read_i, 0);
        checkOutput("i_done_resp", i_pmem_resp, 0);
        cyc();
        checkOutput("i_idle_read", read_i, 0);

        // D-cache write-back; data must stay captured when the input changes
        $display("[TB] D write");
        applyStimulus(0, 0, 1, 32'h0, 32'h0000_2040, PAT_A5, 32'hFFFF_FFFF);
        cyc();
        checkOutput("d_write_i", write_i, 1);
        checkOutput("d_read_i", read_i, 0);
        checkOutput("d_ca_address", ca_address, 32'h0000_2040);
        checkOutput("d_ca_wdata", ca_wdata, PAT_A5);
        checkOutput("d_ca_mbe", ca_mbe, 32'hFFFF_FFFF);
        d_pmem_wdata = PAT_5A;
        cyc();
        checkOutput("d_wdata_stable", ca_wdata, PAT_A5);
        resp_o = 1'b1;
        d_pmem_write = 1'b0;
        #1;
        checkOutput("d_resp", d_pmem_resp, 1);
        checkOutput("d_other_resp", i_pmem_resp, 0);
        cyc();
        resp_o = 1'b0;
        #1;
        checkOutput("d_done_write", write_i, 0);
        cyc();

        // Ties after reset: D first, then I; later tie with D last favours I
        $display("[TB] tie arbitration");
        doReset();
        applyStimulus(1, 1, 0, IA, DA, '0, '0);
        cyc();
        checkOutput("tie1_addr", ca_address, DA);
        checkOutput("tie1_count", conflict_count, 1);
        resp_o = 1'b1;
        d_pmem_read = 1'b0;
        #1;
        checkOutput("tie1_d_resp", d_pmem_resp, 1);
        checkOutput("tie1_i_resp", i_pmem_resp, 0);
        cyc();
        resp_o = 1'b0;
        cyc();
        cyc();
        checkOutput("tie1_then_i_addr", ca_address, IA);
        checkOutput("tie1_then_i_count", conflict_count, 1);
        resp_o = 1'b1;
        i_pmem_read = 1'b0;
        #1;
        checkOutput("tie1_then_i_resp", i_pmem_resp, 1);
        cyc();
        resp_o = 1'b0;
        cyc();
        d_pmem_read = 1'b1;
        cyc();
        checkOutput("d_only_addr", ca_address, DA);
        resp_o = 1'b1;
        d_pmem_read = 1'b0;
        cyc();
        resp_o = 1'b0;
        cyc();
        applyStimulus(1, 1, 0, IA, DA, '0, '0);
        cyc();
        checkOutput("tie2_addr", ca_address, IA);
        checkOutput("tie2_count", conflict_count, 2);
        resp_o = 1'b1;
        i_pmem_read = 1'b0;
        #1;
        checkOutput("tie2_i_resp", i_pmem_resp, 1);
        cyc();
        resp_o = 1'b0;
        cyc();
        cyc();
        checkOutput("tie2_then_d_addr", ca_address, DA);
        resp_o = 1'b1;
        d_pmem_read = 1'b0;
        cyc();
        resp_o = 1'b0;
        cyc();

        // Continuous contention: grants alternate D,I,D,... with two idle strobe cycles between
        $display("[TB] back-to-back contention");
        doReset();
        applyStimulus(1, 1, 0, IA, DA, '0, '0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            checkOutput("rr_read_i", read_i, 1);
            checkOutput("rr_addr", ca_address, (k % 2 == 0) ? DA : IA);
            checkOutput("rr_count", conflict_count, k + 1);
            resp_o = 1'b1;
            #1;
            checkOutput("rr_resp", (k % 2 == 0) ? d_pmem_resp : i_pmem_resp, 1);
            cyc();
            resp_o = 1'b0;
            #1;
            checkOutput("rr_gap1", read_i, 0);
            cyc();
            checkOutput("rr_gap2", read_i, 0);
        end
        for (int k = 0; k < 12; k++) begin
            cyc();
            resp_o = 1'b1;
            cyc();
            resp_o = 1'b0;
            cyc();
        end
        checkOutput("count_saturated", conflict_count, 4'hF);
        applyStimulus(0, 0, 0, IA, DA, '0, '0);

        // Reset while D waits for the adaptor; stray responses are ignored
        $display("[TB] reset mid-transfer");
        applyStimulus(0, 1, 0, IA, 32'h3000_0000, '0, '0);
        cyc();
        checkOutput("mid_read_i", read_i, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_read_i", read_i, 0);
        checkOutput("mid_rst_count", conflict_count, 0);
        checkOutput("mid_rst_addr", ca_address, 0);
        d_pmem_read = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        resp_o = 1'b1;
        #1;
        checkOutput("stray_d_resp", d_pmem_resp, 0);
        checkOutput("stray_i_resp", i_pmem_resp, 0);
        cyc();
        resp_o = 1'b0;
        #1;
        checkOutput("stray_read_i", read_i, 0);
        checkOutput("stray_write_i", write_i, 0);
        applyStimulus(1, 0, 0, 32'h4000_0010, 32'h0, '0, '0);
        cyc();
        checkOutput("post_rst_read_i", read_i, 1);
        checkOutput("post_rst_addr", ca_address, 32'h4000_0000);
        resp_o = 1'b1;
        i_pmem_read = 1'b0;
        #1;
        checkOutput("post_rst_i_resp", i_pmem_resp, 1);
        cyc();
        resp_o = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
